alu_iter: RTL and testbench
===========================

Name: alu_iter

Overview:
- Parametrised successor to the single-cycle RV32I ALU.
- Executes the base integer ops plus the RV32M multiply/divide/remainder ops behind a valid/ready handshake.
- Base ops complete in one cycle; MUL/DIV-class ops use an iterative radix-2 engine.
- Sits in the EX stage. The pipeline stalls on in_ready/out_valid and uses flush on redirect.

Parameters:
- WIDTH, 32: operand/result width; power of 2, >= 8.
- SHW, log2(WIDTH): derived localparam giving the shift-amount width; not overridable.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst_n  in  1  synchronous active-low reset.
- flush  in  1  synchronous abort of any in-flight or held op.
- in_valid  in  1  operands and op valid.
- in_ready  out  1  block can accept an op this cycle.
- op  in  5  operation code, listed under Behaviour.
- a  in  WIDTH  operand A; rs1 / dividend / multiplicand.
- b  in  WIDTH  operand B; rs2 / divisor / multiplier.
- out_valid  out  1  result valid; held until accepted.
- out_ready  in  1  consumer accepts the result.
- result  out  WIDTH  result value.

Behaviour:
- Op codes:
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 SRA, 8 SLT, 9 SLTU.
  - 16 MUL, 17 MULH, 18 MULHSU, 19 MULHU, 20 DIV, 21 DIVU, 22 REM, 23 REMU.
  - Any other code: single-cycle op with result 0.
- Base op arithmetic:
  - Shifts use b[SHW-1:0] only.
  - SLT/SLTU return 1 or 0, zero-extended.
  - ADD/SUB wrap modulo 2^WIDTH.
- States and transitions:
  - IDLE -> DONE: on accept of a base op or a fast-path divide; result registered.
  - IDLE -> CALC: on accept of MUL/DIV class; load |a| and |b| per signedness; record sign flags; counter = WIDTH-1.
  - CALC -> FIX: when counter reaches 0. In CALC, one shift-add (mul) or restoring shift-subtract (div) step per cycle; counter decrements.
  - FIX -> DONE: apply sign correction and select the high/low/quotient/remainder word.
  - DONE -> IDLE: when out_ready and no new accept.
- Handshake:
  - Accept = in_valid && in_ready.
  - in_ready = (state==IDLE) || (state==DONE && out_ready), so back-to-back base ops give one result per cycle.
  - out_valid = (state==DONE).
  - result and out_valid stay stable while out_valid && !out_ready.
- Latency, with accept in cycle T:
  - Base ops: out_valid at T+1.
  - MUL class: out_valid at T+WIDTH+2.
  - Div class, normal case: out_valid at T+WIDTH+2.
- Multiply signedness:
  - MUL: low WIDTH bits of the product.
  - MULH: high bits, signed x signed.
  - MULHSU: high bits, signed a x unsigned b.
  - MULHU: high bits, unsigned x unsigned.
- Divide rules:
  - Quotient truncates toward zero.
  - Remainder takes the sign of the dividend.
- Divide fast path: no iteration, out_valid at T+1.
  - b==0: DIV/DIVU give all-ones; REM/REMU give a.
  - Signed a==MIN and b==-1: DIV gives MIN; REM gives 0.
- flush:
  - Takes priority over all other events.
  - Next state is IDLE, out_valid=0; any in-flight or held result is discarded.
  - An op presented with in_valid in the same cycle as flush is not accepted.
- Reset (rst_n==0 at a clock edge): state IDLE, out_valid 0, result 0, counter 0. Reset mid-CALC aborts identically.
- Upper output bits are never X after reset; all internal registers are reset.

Test Plan:
- Base ops, WIDTH=32, out_ready=1, consecutive cycles:
  - ADD 0xFFFFFFFF+1 -> 0x00000000.
  - SRA 0x80000000 by b=0x24 -> 0xF8000000, shift of 4.
  - SLTU 1,0xFFFFFFFF -> 1.
  - Required: one result per cycle, each at T+1.
- MULH 0x80000000 x 0x80000000 -> 0x40000000.
- MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF.
- MUL 7 x 6 -> 42.
- For each of the above: out_valid exactly at T+34.
- DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2. All at T+34.
- Divide fast path, each at T+1:
  - DIV 5/0 -> 0xFFFFFFFF; REM 5/0 -> 5.
  - DIV 0x80000000/-1 -> 0x80000000; REM 0x80000000/-1 -> 0.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid -> result stable, in_ready=0; release -> in_ready=1 in the same cycle.
- Abort:
  - flush in cycle T+10 of a DIV -> out_valid never asserts, in_ready=1 next cycle.
  - rst_n=0 mid-CALC -> IDLE, out_valid=0, result=0.
- Repeat the directed tests at WIDTH=8: MUL class latency T+10; MULHU 0xFF x 0xFF -> 0xFE.

Source files
------------

// File: rtl/alu_iter.sv
// Iterative RV32I/RV32M ALU: base ops in one cycle, MUL/DIV class through a
// radix-2 shift-add / restoring-divide engine behind a valid/ready handshake.
module alu_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result
);

    localparam int SHW = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] MIN_VAL  = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] ONES_VAL = '1;

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

    state_t state_q, state_d;

    logic [4:0]       op_q;
    logic [WIDTH-1:0] hi_q, lo_q, mcand_q, result_q;
    logic             neg_q, neg_rem_q;
    logic [SHW-1:0]   cnt_q;

    // Handshake: an op moves on accept = in_valid && in_ready && !flush; a
    // result is held in DONE until out_ready, and DONE can accept the next op
    // in the same cycle its result is taken.
    logic accept;
    assign in_ready  = (state_q == S_IDLE) || ((state_q == S_DONE) && out_ready);
    assign out_valid = (state_q == S_DONE);
    assign result    = result_q;
    assign accept    = in_valid && in_ready && !flush;

    // Decode of the incoming op
    logic           is_iter, is_div, div_signed, div_rem;
    logic           div_by_zero, div_ovf, fast_div, start_iter;
    logic           a_sgn, b_sgn, neg_a, neg_b;
    logic [WIDTH-1:0] mag_a, mag_b;
    logic [SHW-1:0]   shamt;

    assign is_iter     = (op[4:3] == 2'b10);
    assign is_div      = (op[4:2] == 3'b101);
    assign div_signed  = ~op[0];
    assign div_rem     = op[1];
    assign div_by_zero = (b == '0);
    assign div_ovf     = div_signed && (a == MIN_VAL) && (b == ONES_VAL);
    assign fast_div    = is_div && (div_by_zero || div_ovf);
    assign start_iter  = is_iter && !fast_div;
    assign shamt       = b[SHW-1:0];

    assign a_sgn = is_div ? div_signed : ((op[1:0] == 2'b01) || (op[1:0] == 2'b10));
    assign b_sgn = is_div ? div_signed : (op[1:0] == 2'b01);
    assign neg_a = a_sgn && a[WIDTH-1];
    assign neg_b = b_sgn && b[WIDTH-1];
    assign mag_a = neg_a ? -a : a;
    assign mag_b = neg_b ? -b : b;

    logic [WIDTH-1:0] base_res, fast_res, accept_res;

    always_comb begin
        base_res = '0;
        case (op)
            5'd0:    base_res = a + b;
            5'd1:    base_res = a - b;
            5'd2:    base_res = a & b;
            5'd3:    base_res = a | b;
            5'd4:    base_res = a ^ b;
            5'd5:    base_res = a << shamt;
            5'd6:    base_res = a >> shamt;
            5'd7:    base_res = $signed(a) >>> shamt;
            5'd8:    base_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            5'd9:    base_res = {{(WIDTH-1){1'b0}}, (a < b)};
            default: base_res = '0;
        endcase
    end

    assign fast_res   = div_by_zero ? (div_rem ? a : ONES_VAL) : (div_rem ? '0 : MIN_VAL);
    assign accept_res = fast_div ? fast_res : base_res;

    // One iteration step; op_q[2] separates the divide class from multiply.
    logic [WIDTH:0]   mul_sum, div_shift;
    logic [WIDTH-1:0] div_diff;
    logic             div_ge;

    assign mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, mcand_q} : {(WIDTH+1){1'b0}});
    assign div_shift = {hi_q, lo_q[WIDTH-1]};
    assign div_ge    = (div_shift >= {1'b0, mcand_q});
    assign div_diff  = div_shift[WIDTH-1:0] - mcand_q;

    // Sign correction and word select once the magnitudes are complete
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix, fix_res;

    assign prod_fix = neg_q ? -{hi_q, lo_q} : {hi_q, lo_q};
    assign quo_fix  = neg_q ? -lo_q : lo_q;
    assign rem_fix  = neg_rem_q ? -hi_q : hi_q;
    assign fix_res  = op_q[2] ? (op_q[1] ? rem_fix : quo_fix)
                              : ((op_q[1:0] == 2'b00) ? prod_fix[WIDTH-1:0]
                                                      : prod_fix[2*WIDTH-1:WIDTH]);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (accept) state_d = start_iter ? S_CALC : S_DONE;
            end
            S_CALC: begin
                if (cnt_q == '0) state_d = S_FIX;
            end
            S_FIX: begin
                state_d = S_DONE;
            end
            S_DONE: begin
                if (accept)         state_d = start_iter ? S_CALC : S_DONE;
                else if (out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        if (flush) state_d = S_IDLE;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            op_q      <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            mcand_q   <= '0;
            neg_q     <= 1'b0;
            neg_rem_q <= 1'b0;
            cnt_q     <= '0;
            result_q  <= '0;
        end else if (!flush) begin
            if (accept) begin
                op_q <= op;
                if (start_iter) begin
                    // Multiply: lo holds the multiplier; divide: lo holds the dividend.
                    hi_q      <= '0;
                    lo_q      <= is_div ? mag_a : mag_b;
                    mcand_q   <= is_div ? mag_b : mag_a;
                    neg_q     <= neg_a ^ neg_b;
                    neg_rem_q <= neg_a;
                    cnt_q     <= SHW'(WIDTH - 1);
                end else begin
                    result_q <= accept_res;
                end
            end else if (state_q == S_CALC) begin
                if (cnt_q != '0) cnt_q <= cnt_q - SHW'(1);
                if (op_q[2]) begin
                    hi_q <= div_ge ? div_diff : div_shift[WIDTH-1:0];
                    lo_q <= {lo_q[WIDTH-2:0], div_ge};
                end else begin
                    hi_q <= mul_sum[WIDTH:1];
                    lo_q <= {mul_sum[0], lo_q[WIDTH-1:1]};
                end
            end else if (state_q == S_FIX) begin
                result_q <= fix_res;
            end
        end
    end

endmodule

// File: tb/tb_alu_iter.sv
// Bench for alu_iter: 32-bit and 8-bit instances driven from shared stimulus,
// results and latencies compared against an arithmetic reference model.
module tb_alu_iter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, flush, in_valid, out_ready, sel8;
    logic [4:0]  op;
    logic [31:0] a, b;
    logic        ir32, ov32, ir8, ov8;
    logic [31:0] res32;
    logic [7:0]  res8;

    alu_iter #(.WIDTH(32)) dut32 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid && !sel8), .in_ready(ir32),
        .op(op), .a(a), .b(b),
        .out_valid(ov32), .out_ready(out_ready), .result(res32)
    );

    alu_iter #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid && sel8), .in_ready(ir8),
        .op(op), .a(a[7:0]), .b(b[7:0]),
        .out_valid(ov8), .out_ready(out_ready), .result(res8)
    );

    logic        obs_ready, obs_valid;
    logic [31:0] obs_result;
    assign obs_ready  = sel8 ? ir8 : ir32;
    assign obs_valid  = sel8 ? ov8 : ov32;
    assign obs_result = sel8 ? {24'b0, res8} : res32;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference model: plain integer arithmetic on w-bit operands.
    function automatic logic [31:0] ref_alu(input int w, input logic [4:0] o,
                                            input logic [31:0] x, input logic [31:0] y);
        logic [63:0] mask, ux, uy, r;
        longint sx, sy;
        int sh;
        mask = (64'd1 << w) - 64'd1;
        ux = {32'b0, x} & mask;
        uy = {32'b0, y} & mask;
        sx = longint'(ux);
        sy = longint'(uy);
        if (ux[w-1]) sx = sx - longint'(64'd1 << w);
        if (uy[w-1]) sy = sy - longint'(64'd1 << w);
        sh = int'(uy % 64'(w));
        case (o)
            5'd0:  r = ux + uy;
            5'd1:  r = ux - uy;
            5'd2:  r = ux & uy;
            5'd3:  r = ux | uy;
            5'd4:  r = ux ^ uy;
            5'd5:  r = ux << sh;
            5'd6:  r = ux >> sh;
            5'd7:  r = 64'(sx >>> sh);
            5'd8:  r = (sx < sy) ? 64'd1 : 64'd0;
            5'd9:  r = (ux < uy) ? 64'd1 : 64'd0;
            5'd16: r = ux * uy;
            5'd17: r = 64'((sx * sy) >>> w);
            5'd18: r = 64'((sx * longint'(uy)) >>> w);
            5'd19: r = (ux * uy) >> w;
            5'd20: r = (uy == 0) ? mask : 64'(sx / sy);
            5'd21: r = (uy == 0) ? mask : ux / uy;
            5'd22: r = (uy == 0) ? ux : 64'(sx % sy);
            5'd23: r = (uy == 0) ? ux : ux % uy;
            default: r = 64'd0;
        endcase
        return 32'(r & mask);
    endfunction

    function automatic int ref_lat(input int w, input logic [4:0] o,
                                   input logic [31:0] x, input logic [31:0] y);
        logic [31:0] mask;
        mask = 32'((64'd1 << w) - 64'd1);
        if (o inside {[16:19]}) return w + 2;
        if (o inside {[20:23]}) begin
            if ((y & mask) == 0) return 1;
            if ((o == 5'd20 || o == 5'd22) && (x & mask) == (32'd1 << (w - 1)) && (y & mask) == mask)
                return 1;
            return w + 2;
        end
        return 1;
    endfunction

    // Issue one op with out_ready=1, measure cycles from accept to out_valid.
    task automatic run_op(input string tag, input logic [4:0] o, input logic [31:0] x,
                          input logic [31:0] y, input logic [31:0] exp, input int exp_lat);
        int guard;
        int lat;
        @(negedge clk);
        op = o; a = x; b = y; in_valid = 1'b1; out_ready = 1'b1;
        guard = 0;
        while (!obs_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        while (!obs_valid && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        check({tag, "_res"}, obs_result, exp);
    endtask

    task automatic run_rand(input string tag, input logic [4:0] o, input logic [31:0] x,
                            input logic [31:0] y);
        int w;
        w = sel8 ? 8 : 32;
        if (w == 8) begin
            x = x & 32'hFF;
            y = y & 32'hFF;
        end
        run_op(tag, o, x, y, ref_alu(w, o, x, y), ref_lat(w, o, x, y));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [4:0]  o;
        logic [31:0] x, y;
        int          cnt;
        logic        seen;

        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1; sel8 = 1'b0;
        op = '0; a = '0; b = '0;
        repeat (3) @(negedge clk);
        check("rst_valid32", {31'b0, ov32}, 32'd0);
        check("rst_result32", res32, 32'd0);
        check("rst_ready32", {31'b0, ir32}, 32'd1);
        check("rst_valid8", {31'b0, ov8}, 32'd0);
        check("rst_result8", {24'b0, res8}, 32'd0);
        rst_n = 1'b1;

        // Back-to-back base ops: one result per cycle, each at T+1
        for (int i = 0; i < 23; i++) begin
            @(negedge clk);
            if (i > 0) begin
                check("stream_valid", {31'b0, obs_valid}, 32'd1);
                check("stream_res", obs_result, exp_q.pop_front());
            end
            check("stream_ready", {31'b0, obs_ready}, 32'd1);
            case (i)
                0: begin o = 5'd0; x = 32'hFFFFFFFF; y = 32'd1;        exp_q.push_back(32'h00000000); end
                1: begin o = 5'd7; x = 32'h80000000; y = 32'h24;       exp_q.push_back(32'hF8000000); end
                2: begin o = 5'd9; x = 32'd1;        y = 32'hFFFFFFFF; exp_q.push_back(32'd1); end
                default: begin
                    o = 5'($urandom_range(0, 15)); x = $urandom; y = $urandom;
                    exp_q.push_back(ref_alu(32, o, x, y));
                end
            endcase
            op = o; a = x; b = y; in_valid = 1'b1;
        end
        @(negedge clk);
        in_valid = 1'b0;
        check("stream_last_valid", {31'b0, obs_valid}, 32'd1);
        check("stream_last_res", obs_result, exp_q.pop_front());

        // Iterative ops and divide fast path, WIDTH=32
        run_op("mulh",   5'd17, 32'h80000000, 32'h80000000, 32'h40000000, 34);
        run_op("mulhsu", 5'd18, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 34);
        run_op("mul",    5'd16, 32'd7, 32'd6, 32'd42, 34);
        run_op("div",    5'd20, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 34);
        run_op("rem",    5'd22, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 34);
        run_op("divu",   5'd21, 32'd100, 32'd7, 32'd14, 34);
        run_op("remu",   5'd23, 32'd100, 32'd7, 32'd2, 34);
        run_op("div0",   5'd20, 32'd5, 32'd0, 32'hFFFFFFFF, 1);
        run_op("rem0",   5'd22, 32'd5, 32'd0, 32'd5, 1);
        run_op("divovf", 5'd20, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1);
        run_op("removf", 5'd22, 32'h80000000, 32'hFFFFFFFF, 32'd0, 1);

        for (int i = 0; i < 60; i++) begin
            o = 5'($urandom_range(0, 31));
            x = $urandom;
            y = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
            if ($urandom_range(0, 5) == 0) y = 32'hFFFFFFFF;
            if ($urandom_range(0, 5) == 0) x = 32'h80000000;
            run_rand("rand32", o, x, y);
        end

        // Backpressure: result held and in_ready low while out_ready is low
        @(negedge clk);
        op = 5'd16; a = 32'd7; b = 32'd6; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        cnt = 0;
        while (!obs_valid && cnt < 100) begin
            @(negedge clk);
            cnt++;
        end
        for (int i = 0; i < 5; i++) begin
            check("bp_valid", {31'b0, obs_valid}, 32'd1);
            check("bp_res", obs_result, 32'd42);
            check("bp_ready", {31'b0, obs_ready}, 32'd0);
            @(negedge clk);
        end
        out_ready = 1'b1;
        #1;
        check("bp_release_ready", {31'b0, obs_ready}, 32'd1);

        // Flush in cycle T+10 of a DIV, with a competing op presented alongside
        @(negedge clk);
        op = 5'd20; a = 32'd100; b = 32'd7; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (9) @(negedge clk);
        flush = 1'b1; op = 5'd0; a = 32'd1; b = 32'd1; in_valid = 1'b1;
        @(negedge clk);
        flush = 1'b0; in_valid = 1'b0;
        check("flush_ready", {31'b0, obs_ready}, 32'd1);
        check("flush_valid", {31'b0, obs_valid}, 32'd0);
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (obs_valid) seen = 1'b1;
        end
        check("flush_never_valid", {31'b0, seen}, 32'd0);

        // Reset mid-CALC
        @(negedge clk);
        op = 5'd16; a = 32'd3; b = 32'd5; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("midrst_valid", {31'b0, obs_valid}, 32'd0);
        check("midrst_result", obs_result, 32'd0);
        check("midrst_ready", {31'b0, obs_ready}, 32'd1);
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (obs_valid) seen = 1'b1;
        end
        check("midrst_never_valid", {31'b0, seen}, 32'd0);

        // WIDTH=8 instance
        sel8 = 1'b1;
        run_op("w8_mulhu", 5'd19, 32'hFF, 32'hFF, 32'hFE, 10);
        run_op("w8_mul",   5'd16, 32'd7, 32'd6, 32'd42, 10);
        run_op("w8_mulh",  5'd17, 32'h80, 32'h80, 32'h40, 10);
        run_op("w8_div",   5'd20, 32'hF9, 32'd2, 32'hFD, 10);
        run_op("w8_rem",   5'd22, 32'hF9, 32'd2, 32'hFF, 10);
        run_op("w8_divu",  5'd21, 32'd100, 32'd7, 32'd14, 10);
        run_op("w8_div0",  5'd20, 32'd5, 32'd0, 32'hFF, 1);
        run_op("w8_rem0",  5'd22, 32'd5, 32'd0, 32'd5, 1);
        run_op("w8_divovf", 5'd20, 32'h80, 32'hFF, 32'h80, 1);
        run_op("w8_removf", 5'd22, 32'h80, 32'hFF, 32'd0, 1);
        run_op("w8_add",   5'd0, 32'hFF, 32'd1, 32'd0, 1);
        run_op("w8_sra",   5'd7, 32'h80, 32'h0C, 32'hF8, 1);
        for (int i = 0; i < 40; i++) begin
            o = 5'($urandom_range(0, 31));
            x = $urandom;
            y = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
            if ($urandom_range(0, 5) == 0) y = 32'hFF;
            if ($urandom_range(0, 5) == 0) x = 32'h80;
            run_rand("rand8", o, x, y);
        end
        sel8 = 1'b0;

        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
